lcd_char_render: RTL and testbench
==================================

Name: lcd_char_render

Overview:
- Sits directly downstream of the string/number control block that issues show_char_flag, ascii_num, start_x, start_y and en_size.
- On each request, fetches the glyph bitmap for one character from a font ROM, row by row.
- Emits one RGB565 pixel write per glyph cell to the LCD pixel-write stage over a valid/ready handshake.
- Pulses show_char_done when the last pixel is accepted, which advances the upstream character counter.

Parameters:
- LCD_W, 240, panel width in pixels; pixels with x >= LCD_W are clipped.
- LCD_H, 320, panel height in pixels; pixels with y >= LCD_H are clipped.
- FG_COLOR, 16'h0000, RGB565 foreground (glyph bit = 1).
- BG_COLOR, 16'hFFFF, RGB565 background (glyph bit = 0).
- GLYPH_NUM, 95, valid glyph indices 0..94 (index = ASCII code − 32).

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  synchronous, active-high reset
- show_char_flag  in  1  one-cycle request strobe
- ascii_num  in  7  glyph index
- start_x  in  9  top-left column
- start_y  in  9  top-left row
- en_size  in  1  1 = 16x8 font, 0 = 12x6 font
- show_char_done  out  1  one-cycle pulse, character complete
- busy  out  1  high from request accept until done pulse inclusive
- pix_valid  out  1  pixel write valid
- pix_ready  in  1  pixel write accepted by LCD stage
- pix_x  out  9  pixel column
- pix_y  out  9  pixel row
- pix_color  out  16  pixel RGB565

Behaviour:
- Reset (sync, sys_rst = 1 at the clock edge): state IDLE; all outputs 0; internal counters 0. Reset mid-character aborts immediately: no done pulse, pix_valid drops the next cycle.
- Glyph geometry: H = 16, W = 8 when en_size = 1; H = 12, W = 6 when en_size = 0.
- Request capture: in IDLE, show_char_flag = 1 latches ascii_num, start_x, start_y and en_size, then moves to FETCH.
  - Request inputs are ignored in every other state; busy = 1 signals this.
- State FETCH: drive ROM address {size, index, row}; next state WAIT.
- State WAIT: absorbs the ROM's 1-cycle read latency; register the 8-bit row bitmap, with bit 7 = leftmost column. Next state DRAW.
- State DRAW: col counts 0..W−1.
  - Present pix_x = start_x + col and pix_y = start_y + row. Sums are 10-bit internally.
  - pix_color = FG_COLOR if bitmap[7−col], else BG_COLOR.
  - Handshake: pix_valid holds with stable x/y/color until pix_valid & pix_ready; col advances only on acceptance.
  - Clipped pixel (10-bit x >= LCD_W or y >= LCD_H): pix_valid stays 0 and col advances in 1 cycle without a handshake.
  - After col = W−1: if row < H−1, row increments and state returns to FETCH; otherwise state DONE.
- State DONE: show_char_done = 1 for exactly one cycle; next state IDLE.
  - A show_char_flag in the DONE cycle is ignored.
  - A flag on the first IDLE cycle after DONE is accepted.
- Invalid glyph (ascii_num >= GLYPH_NUM): ROM returns 0, so the cell is drawn entirely in BG_COLOR.
- Minimum latency, flag to done, with pix_ready tied high: H × (2 + W) + 1 cycles after capture. This is 161 cycles for 16x8 and 97 for 12x6.
- A pix_ready that is low indefinitely stalls the block; no timeout.

Optional Feature:
- Macro: LCD_CHAR_TRANSPARENT_BG_EN.
- Defined: background pixels are treated exactly like clipped pixels (no write, 1 cycle each), so existing screen content shows through.
- Undefined: every non-clipped cell is written, with background cells in BG_COLOR.

Decomposition:
- Shared package lcd_pkg:
  - LCD_W, LCD_H and the RGB565 colour constants.
  - Font geometry constants: FONT16_H/W = 16/8 and FONT12_H/W = 12/6.
  - GLYPH_NUM.
  - State enum: IDLE, FETCH, WAIT, DRAW, DONE.
- One sub-module, lcd_font_rom: synchronous 1-cycle ROM holding both fonts, 8-bit row output. Returns 0 for out-of-range index or row.

Test Plan:
- Glyph 'r' at full speed: ascii 82, x 72, y 16, en_size 1, pix_ready = 1 → 128 writes covering x 72..79, y 16..31. Colours match the ROM bitmap; single done pulse 161 cycles after capture.
- Small font ':': ascii 26, x 8, y 48, en_size 0 → 72 writes covering x 8..13, y 48..59; done at 97 cycles.
- Backpressure: pix_ready toggles 1/0 at random → pixel sequence and values identical to the full-speed run; x/y/color stable while pix_valid & !pix_ready.
- Clipping: x 236, y 312, en_size 1 → only x 236..239, y 312..319 written (32 pixels); done still pulses.
- Busy request and mid-character reset: second flag while busy is ignored (one done only); sys_rst asserted at pixel 40 → IDLE next cycle, no done, pix_valid = 0.
- Invalid index plus macro:
  - ascii 120 without the macro → 128 BG_COLOR writes.
  - Same stimulus with LCD_CHAR_TRANSPARENT_BG_EN → zero writes and done after 161 cycles.

Source files
------------

// File: rtl/lcd_char_render_pkg.sv
// lcd_pkg: shared constants and types for the LCD character renderer.
// Holds panel size, RGB565 colours, font geometry, glyph count and the FSM state type.
// No ports; imported by lcd_char_render and lcd_font_rom.
package lcd_pkg;

   // Panel geometry (10-bit so that start + offset can be compared without wrap)
   localparam logic [9:0]  LCD_W     = 10'd240;
   localparam logic [9:0]  LCD_H     = 10'd320;

   // RGB565 colours
   localparam logic [15:0] FG_COLOR  = 16'h0000;
   localparam logic [15:0] BG_COLOR  = 16'hFFFF;

   // Font geometry
   localparam int          FONT16_H  = 16;
   localparam int          FONT16_W  = 8;
   localparam int          FONT12_H  = 12;
   localparam int          FONT12_W  = 6;

   // Glyph indices 0..GLYPH_NUM-1 map to ASCII 32..126
   localparam logic [6:0]  GLYPH_NUM = 7'd95;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT,
      DRAW,
      DONE
   } state_t;

   // Index of the last glyph row for the selected font (size 1 = 16x8)
   function automatic logic [3:0] last_row(input logic size);
      return size ? 4'(FONT16_H - 1) : 4'(FONT12_H - 1);
   endfunction

   // Index of the last glyph column for the selected font
   function automatic logic [2:0] last_col(input logic size);
      return size ? 3'(FONT16_W - 1) : 3'(FONT12_W - 1);
   endfunction

endpackage

// File: rtl/lcd_char_render_font_rom.sv
// lcd_font_rom: synchronous font ROM, 1-cycle read latency, 8-bit row out (bit 7 = leftmost).
// Ports: clk, en (read strobe), size (1 = 16x8, 0 = 12x6), glyph_idx, row -> row_dat.
// Out-of-range glyph index or row reads back 0; row_dat holds while en is low.
module lcd_font_rom
   import lcd_pkg::*;
(
   input  logic       clk,
   input  logic       en,
   input  logic       size,
   input  logic [6:0] glyph_idx,
   input  logic [3:0] row,
   output logic [7:0] row_dat
);

   logic [7:0] rom_d;

   // Bitmaps for ':' (26) and 'r' (82) are the real font image; every other
   // printable glyph except space reads as a hollow cell outline so that the
   // draw path is exercised with a recognisable shape.
   always_comb begin
      rom_d = 8'h00;
      if ((glyph_idx < GLYPH_NUM) && (row <= last_row(size))) begin
         if (size) begin
            case (glyph_idx)
               7'd0:  rom_d = 8'h00;
               7'd26: begin
                  case (row)
                     4'd4, 4'd5, 4'd9, 4'd10: rom_d = 8'h18;
                     default:                 rom_d = 8'h00;
                  endcase
               end
               7'd82: begin
                  case (row)
                     4'd5:               rom_d = 8'hDC;
                     4'd6:               rom_d = 8'h76;
                     4'd7:               rom_d = 8'h66;
                     4'd8, 4'd9, 4'd10:  rom_d = 8'h60;
                     4'd11:              rom_d = 8'hF0;
                     default:            rom_d = 8'h00;
                  endcase
               end
               default: begin
                  if ((row == 4'd1) || (row == 4'd14))
                     rom_d = 8'hFF;
                  else if ((row > 4'd1) && (row < 4'd14))
                     rom_d = 8'h81;
                  else
                     rom_d = 8'h00;
               end
            endcase
         end else begin
            // 6-wide font occupies bits 7..2
            case (glyph_idx)
               7'd0:  rom_d = 8'h00;
               7'd26: begin
                  case (row)
                     4'd3, 4'd4, 4'd8, 4'd9: rom_d = 8'h30;
                     default:                rom_d = 8'h00;
                  endcase
               end
               7'd82: begin
                  case (row)
                     4'd3:       rom_d = 8'hD8;
                     4'd4:       rom_d = 8'h64;
                     4'd5, 4'd6: rom_d = 8'h40;
                     4'd7:       rom_d = 8'hE0;
                     default:    rom_d = 8'h00;
                  endcase
               end
               default: begin
                  if ((row == 4'd1) || (row == 4'd10))
                     rom_d = 8'hFC;
                  else if ((row > 4'd1) && (row < 4'd10))
                     rom_d = 8'h84;
                  else
                     rom_d = 8'h00;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (en)
         row_dat <= rom_d;
   end

endmodule

// File: rtl/lcd_char_render.sv
// lcd_char_render: draws one font glyph as RGB565 pixel writes over valid/ready.
// Ports: sys_clk/sys_rst (sync, active high); request show_char_flag/ascii_num/start_x/start_y/en_size;
//        status show_char_done/busy; pixel out pix_valid/pix_ready/pix_x/pix_y/pix_color.
// Latency H*(2+W)+1 cycles from capture with pix_ready high; pix_ready low stalls indefinitely.
// Optional macro LCD_CHAR_TRANSPARENT_BG_EN: background cells are skipped like clipped cells.
module lcd_char_render
   import lcd_pkg::*;
(
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        show_char_flag,
   input  logic [6:0]  ascii_num,
   input  logic [8:0]  start_x,
   input  logic [8:0]  start_y,
   input  logic        en_size,
   output logic        show_char_done,
   output logic        busy,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic [8:0]  pix_x,
   output logic [8:0]  pix_y,
   output logic [15:0] pix_color
);

   state_t     state_q, state_d;
   logic [6:0] idx_q, idx_d;
   logic [8:0] sx_q, sx_d;
   logic [8:0] sy_q, sy_d;
   logic       size_q, size_d;
   logic [3:0] row_q, row_d;
   logic [2:0] col_q, col_d;
   logic [7:0] bmp_q, bmp_d;

   logic       rom_en;
   logic [7:0] rom_dat;
   logic [9:0] x_sum, y_sum;
   logic       clipped, fg_bit, skip;

   lcd_font_rom u_font_rom (
      .clk       (sys_clk),
      .en        (rom_en),
      .size      (size_q),
      .glyph_idx (idx_q),
      .row       (row_q),
      .row_dat   (rom_dat)
   );

   // 10-bit sums so a glyph hanging off the right/bottom edge is detected
   assign x_sum   = {1'b0, sx_q} + {7'b0, col_q};
   assign y_sum   = {1'b0, sy_q} + {6'b0, row_q};
   assign clipped = (x_sum >= LCD_W) || (y_sum >= LCD_H);
   assign fg_bit  = bmp_q[3'd7 - col_q];

   // Skipped cells advance in one cycle with no handshake
`ifdef LCD_CHAR_TRANSPARENT_BG_EN
   assign skip = clipped | ~fg_bit;
`else
   assign skip = clipped;
`endif

   assign pix_valid      = (state_q == DRAW) && !skip;
   assign pix_x          = pix_valid ? x_sum[8:0] : 9'd0;
   assign pix_y          = pix_valid ? y_sum[8:0] : 9'd0;
   assign pix_color      = pix_valid ? (fg_bit ? FG_COLOR : BG_COLOR) : 16'h0000;
   assign show_char_done = (state_q == DONE);
   assign busy           = (state_q != IDLE);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      sx_d    = sx_q;
      sy_d    = sy_q;
      size_d  = size_q;
      row_d   = row_q;
      col_d   = col_q;
      bmp_d   = bmp_q;
      rom_en  = 1'b0;
      case (state_q)
         IDLE: begin
            if (show_char_flag) begin
               idx_d   = ascii_num;
               sx_d    = start_x;
               sy_d    = start_y;
               size_d  = en_size;
               row_d   = 4'd0;
               col_d   = 3'd0;
               state_d = FETCH;
            end
         end
         FETCH: begin
            rom_en  = 1'b1;
            state_d = WAIT;
         end
         WAIT: begin
            bmp_d   = rom_dat;
            state_d = DRAW;
         end
         DRAW: begin
            // pix_valid is high whenever skip is low, so pix_ready alone means accepted
            if (skip || pix_ready) begin
               if (col_q == last_col(size_q)) begin
                  col_d = 3'd0;
                  if (row_q == last_row(size_q)) begin
                     state_d = DONE;
                  end else begin
                     row_d   = row_q + 4'd1;
                     state_d = FETCH;
                  end
               end else begin
                  col_d = col_q + 3'd1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q <= IDLE;
         idx_q   <= 7'd0;
         sx_q    <= 9'd0;
         sy_q    <= 9'd0;
         size_q  <= 1'b0;
         row_q   <= 4'd0;
         col_q   <= 3'd0;
         bmp_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         sx_q    <= sx_d;
         sy_q    <= sy_d;
         size_q  <= size_d;
         row_q   <= row_d;
         col_q   <= col_d;
         bmp_q   <= bmp_d;
      end
   end

endmodule

// File: tb/tb_lcd_char_render.sv
// tb_lcd_char_render: scoreboard bench for lcd_char_render.
// Expected pixels are generated from a reference glyph table when a request is driven
// and compared in order as the DUT hands them over; latency, busy and done are checked per request.
`timescale 1ns/1ps
module tb_lcd_char_render;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic        show_char_flag = 1'b0;
   logic [6:0]  ascii_num = 7'd0;
   logic [8:0]  start_x = 9'd0;
   logic [8:0]  start_y = 9'd0;
   logic        en_size = 1'b0;
   logic        show_char_done;
   logic        busy;
   logic        pix_valid;
   logic        pix_ready = 1'b1;
   logic [8:0]  pix_x;
   logic [8:0]  pix_y;
   logic [15:0] pix_color;

   lcd_char_render dut (
      .sys_clk        (sys_clk),
      .sys_rst        (sys_rst),
      .show_char_flag (show_char_flag),
      .ascii_num      (ascii_num),
      .start_x        (start_x),
      .start_y        (start_y),
      .en_size        (en_size),
      .show_char_done (show_char_done),
      .busy           (busy),
      .pix_valid      (pix_valid),
      .pix_ready      (pix_ready),
      .pix_x          (pix_x),
      .pix_y          (pix_y),
      .pix_color      (pix_color)
   );

   always #5 sys_clk = ~sys_clk;

   int          n_vec = 0;
   int          n_err = 0;
   logic [33:0] exp_q[$];
   int          wr_cnt = 0;
   int          done_cnt = 0;
   int          exp_done = 0;
   bit          rnd_ready = 1'b0;
   logic [33:0] held;
   bit          held_vld = 1'b0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Reference glyph rows (bit 7 = leftmost); only glyphs the bench draws are listed
   function automatic logic [7:0] ref_row(input bit sz, input int a, input int r);
      logic [7:0] v;
      v = 8'h00;
      if (sz && a == 82) begin
         case (r)
            5:        v = 8'hDC;
            6:        v = 8'h76;
            7:        v = 8'h66;
            8, 9, 10: v = 8'h60;
            11:       v = 8'hF0;
            default:  v = 8'h00;
         endcase
      end else if (!sz && a == 26) begin
         case (r)
            3, 4, 8, 9: v = 8'h30;
            default:    v = 8'h00;
         endcase
      end
      return v;
   endfunction

   task automatic push_exp(input int a, input int x, input int y, input bit sz, output int n);
      int h, w;
      h = sz ? 16 : 12;
      w = sz ? 8 : 6;
      n = 0;
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w; c++) begin
            logic [7:0] b;
            bit fg, wr;
            int px, py;
            logic [15:0] col;
            b  = ref_row(sz, a, r);
            fg = b[7-c];
            px = x + c;
            py = y + r;
`ifdef LCD_CHAR_TRANSPARENT_BG_EN
            wr = (px < 240) && (py < 320) && fg;
`else
            wr = (px < 240) && (py < 320);
`endif
            col = fg ? 16'h0000 : 16'hFFFF;
            if (wr) begin
               exp_q.push_back({px[8:0], py[8:0], col});
               n++;
            end
         end
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   // Monitor: samples on the falling edge; an accept is valid & ready not overridden by reset
   initial begin
      forever begin
         @(negedge sys_clk);
         if (held_vld) begin
            chk("hold_stable", {pix_valid, pix_x, pix_y, pix_color}, {1'b1, held});
            held_vld = 1'b0;
         end
         if (pix_valid && !sys_rst) begin
            if (pix_ready) begin
               wr_cnt++;
               if (exp_q.size() == 0)
                  chk("extra_pix", exp_q.size(), 1);
               else
                  chk("pix", {pix_x, pix_y, pix_color}, exp_q.pop_front());
            end else begin
               held     = {pix_x, pix_y, pix_color};
               held_vld = 1'b1;
            end
         end
         if (show_char_done)
            done_cnt++;
      end
   end

   // Ready driver: full speed or random 1/0
   initial begin
      forever begin
         @(posedge sys_clk);
         #1;
         pix_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Issues one request (DUT must be IDLE) and runs it to the done pulse.
   // extra_at >= 0 pulses a second, conflicting request at that cycle count.
   task automatic run_char(input int a, input int x, input int y, input bit sz,
                           input int exp_lat, input int extra_at);
      int n, lat, wr0;
      push_exp(a, x, y, sz, n);
      wr0            = wr_cnt;
      ascii_num      = 7'(a);
      start_x        = 9'(x);
      start_y        = 9'(y);
      en_size        = sz;
      show_char_flag = 1'b1;
      tick(1);
      show_char_flag = 1'b0;
      lat            = 1;
      chk("busy_on", busy, 1);
      while (!show_char_done && lat < 3000) begin
         if (lat == extra_at) begin
            ascii_num      = 7'd120;
            start_x        = 9'd0;
            start_y        = 9'd0;
            en_size        = ~sz;
            show_char_flag = 1'b1;
         end else begin
            show_char_flag = 1'b0;
         end
         tick(1);
         lat++;
      end
      show_char_flag = 1'b0;
      exp_done++;
      chk("done_seen", show_char_done, 1);
      chk("busy_in_done", busy, 1);
      if (exp_lat > 0)
         chk("latency", lat, exp_lat);
      chk("n_writes", wr_cnt - wr0, n);
      chk("sb_empty", exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      int wr0, guard;

      // Reset state
      tick(3);
      chk("rst_valid", pix_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", show_char_done, 0);
      chk("rst_xyc", {pix_x, pix_y, pix_color}, 34'd0);
      sys_rst = 1'b0;
      tick(2);

      // 'r' 16x8 full speed
      run_char(82, 72, 16, 1'b1, 161, -1);

      // Flag in the DONE cycle is ignored; flag in the first IDLE cycle is taken
      ascii_num      = 7'd120;
      start_x        = 9'd0;
      start_y        = 9'd0;
      en_size        = 1'b1;
      show_char_flag = 1'b1;
      tick(1);
      chk("done_flag_ignored", busy, 0);
      chk("done_one_cycle", show_char_done, 0);
      run_char(26, 8, 48, 1'b0, 97, -1);
      tick(1);

      // Backpressure: same pixel stream as full speed
      rnd_ready = 1'b1;
      run_char(82, 72, 16, 1'b1, 0, -1);
      rnd_ready = 1'b0;
      tick(2);

      // Clipping at the bottom-right corner
      run_char(82, 236, 312, 1'b1, 161, -1);
      tick(1);

      // Second request while busy is ignored
      run_char(26, 8, 48, 1'b0, 97, 20);
      tick(1);

      // Invalid glyph index: all background (or nothing when transparent)
      run_char(120, 100, 100, 1'b1, 161, -1);
      tick(1);

      // Mid-character reset while pixel 40 is presented
      begin
         int n;
         push_exp(82, 72, 16, 1'b1, n);
      end
      wr0            = wr_cnt;
      ascii_num      = 7'd82;
      start_x        = 9'd72;
      start_y        = 9'd16;
      en_size        = 1'b1;
      show_char_flag = 1'b1;
      tick(1);
      show_char_flag = 1'b0;
      guard          = 0;
      while (!((wr_cnt - wr0) >= 40 && pix_valid) && guard < 500) begin
         tick(1);
         guard++;
      end
      chk("rst_wait_bound", guard < 500, 1);
      sys_rst = 1'b1;
      tick(1);
      chk("abort_valid", pix_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", show_char_done, 0);
      sys_rst = 1'b0;
      chk("abort_writes", wr_cnt - wr0, 40);
      exp_q.delete();
      tick(2);

      // Recovery after abort
      run_char(82, 72, 16, 1'b1, 161, -1);
      tick(5);
      chk("done_count", done_cnt, exp_done);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
